// File: rtl/reg_wr_pkg.sv
// Shared types for the register-file write-port arbiter.
// Slot record and slot state used by reg_wr_arbiter and its interface.
package reg_wr_pkg;

  localparam int DW       = 8;
  localparam int AW       = 2;
  localparam int NREQ_MAX = 4;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_t;

endpackage

// File: rtl/reg_wr_arbiter_if.sv
// Writeback request bus, register-file write port and bypass taps.
// master = requester/read side, slave = arbiter.
interface reg_wr_arbiter_if #(
  parameter int NREQ = 3
) ();
  import reg_wr_pkg::*;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               port_stall;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [1:0]         wr_src;
  logic [NREQ-1:0]    pend;
  logic [AW-1:0]      rd_addr_a;
  logic [AW-1:0]      rd_addr_b;
  logic               byp_hit_a;
  logic               byp_hit_b;
  logic [DW-1:0]      byp_data_a;
  logic [DW-1:0]      byp_data_b;

  modport master (
    output req_valid, req_addr, req_data, port_stall,
    output rd_addr_a, rd_addr_b,
    input  req_ready, wr_en, wr_addr, wr_data, wr_src, pend,
    input  byp_hit_a, byp_hit_b, byp_data_a, byp_data_b
  );

  modport slave (
    input  req_valid, req_addr, req_data, port_stall,
    input  rd_addr_a, rd_addr_b,
    output req_ready, wr_en, wr_addr, wr_data, wr_src, pend,
    output byp_hit_a, byp_hit_b, byp_data_a, byp_data_b
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or after i_ptr wins.
// The pointer register itself is owned by the caller.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0] i_req,
  input  logic [1:0]   i_ptr,
  input  logic         i_stall,
  output logic [N-1:0] o_grant,
  output logic [1:0]   o_next_ptr
);

  always_comb begin
    int best;
    int win;
    int d;
    best       = N;
    win        = 0;
    d          = 0;
    o_grant    = '0;
    o_next_ptr = i_ptr;
    // Rotated distance from the pointer; smallest distance wins.
    for (int j = 0; j < N; j++) begin
      d = (j - int'(i_ptr) + 2 * N) % N;
      if (!i_stall && i_req[j] && d < best) begin
        best = d;
        win  = j;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (best < N && j == win) begin
        o_grant[j] = 1'b1;
        o_next_ptr = 2'((j + 1) % N);
      end
    end
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter for the register-file write port, 1-entry slot per source.
// Define REG_WR_BYPASS_EN to enable read bypass from pending/in-flight writes.
module reg_wr_arbiter
  import reg_wr_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic             clk,
  input  logic             reset,
  reg_wr_arbiter_if.slave  bus
);

  slot_state_t     r_st   [NREQ];
  wr_req_t         r_slot [NREQ];
  logic [1:0]      r_ptr;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data;
  logic [1:0]      r_wr_src;

  wr_req_t         w_in   [NREQ];
  logic [NREQ-1:0] w_full;
  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] w_ready;
  logic [NREQ-1:0] w_acc;
  logic [1:0]      w_next_ptr;
  wr_req_t         w_win;
  logic [1:0]      w_win_idx;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_full[i]    = (r_st[i] == SLOT_FULL);
      w_in[i].addr = bus.req_addr[i*AW +: AW];
      w_in[i].data = bus.req_data[i*DW +: DW];
    end
  end

  rr_arbiter #(.N(NREQ)) u_rr (
    .i_req      (w_full),
    .i_ptr      (r_ptr),
    .i_stall    (bus.port_stall),
    .o_grant    (w_grant),
    .o_next_ptr (w_next_ptr)
  );

  // Keep at most one FULL slot per address so same-address writes stay ordered.
  always_comb begin
    logic [NREQ-1:0] haz;
    logic [NREQ-1:0] acc;
    logic [NREQ-1:0] rdy;
    haz = '0;
    acc = '0;
    rdy = '0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (j != i && w_full[j] && !w_grant[j] &&
            r_slot[j].addr == w_in[i].addr)
          haz[i] = 1'b1;
        if (j < i && acc[j] && w_in[j].addr == w_in[i].addr)
          haz[i] = 1'b1;
      end
      rdy[i] = (!w_full[i] || w_grant[i]) && !haz[i];
      acc[i] = bus.req_valid[i] && rdy[i];
    end
    w_ready = rdy;
    w_acc   = acc;
  end

  always_comb begin
    w_win     = '0;
    w_win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_win     = r_slot[i];
        w_win_idx = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        r_st[i]   <= SLOT_EMPTY;
        r_slot[i] <= '0;
      end
      r_ptr     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_src  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_acc[i]) begin
          r_st[i]   <= SLOT_FULL;
          r_slot[i] <= w_in[i];
        end else if (w_grant[i]) begin
          r_st[i] <= SLOT_EMPTY;
        end
      end
      if (|w_grant) begin
        r_ptr     <= w_next_ptr;
        r_wr_en   <= 1'b1;
        r_wr_addr <= w_win.addr;
        r_wr_data <= w_win.data;
        r_wr_src  <= w_win_idx;
      end else begin
        r_wr_en <= 1'b0;
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.pend      = w_full;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.wr_src    = r_wr_src;

`ifdef REG_WR_BYPASS_EN
  logic          w_hit_a;
  logic          w_hit_b;
  logic [DW-1:0] w_bd_a;
  logic [DW-1:0] w_bd_b;

  // In-flight first, then FULL slots override: slots are always newer.
  always_comb begin
    w_hit_a = 1'b0;
    w_hit_b = 1'b0;
    w_bd_a  = '0;
    w_bd_b  = '0;
    if (r_wr_en && r_wr_addr == bus.rd_addr_a) begin
      w_hit_a = 1'b1;
      w_bd_a  = r_wr_data;
    end
    if (r_wr_en && r_wr_addr == bus.rd_addr_b) begin
      w_hit_b = 1'b1;
      w_bd_b  = r_wr_data;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_full[i] && r_slot[i].addr == bus.rd_addr_a) begin
        w_hit_a = 1'b1;
        w_bd_a  = r_slot[i].data;
      end
      if (w_full[i] && r_slot[i].addr == bus.rd_addr_b) begin
        w_hit_b = 1'b1;
        w_bd_b  = r_slot[i].data;
      end
    end
  end

  assign bus.byp_hit_a  = w_hit_a;
  assign bus.byp_hit_b  = w_hit_b;
  assign bus.byp_data_a = w_bd_a;
  assign bus.byp_data_b = w_bd_b;
`else
  logic w_unused_rd;
  assign w_unused_rd    = ^{bus.rd_addr_a, bus.rd_addr_b};
  assign bus.byp_hit_a  = 1'b0;
  assign bus.byp_hit_b  = 1'b0;
  assign bus.byp_data_a = '0;
  assign bus.byp_data_b = '0;
`endif

endmodule
